edge_detect_bank: RTL and testbench
===================================

# edge_detect_bank

Multi-channel, parametrised edge detector: each of `N_CH` asynchronous inputs is synchronised, debounced, and turned into a one-cycle edge pulse plus a sticky, software-clearable event flag. Edge polarity is selectable per channel. The block sits between raw board inputs (buttons, switches, external strobes) and the control FSMs or register file. It replaces ad-hoc single-bit rising-edge detectors.

## Interface
Parameters:
- `N_CH`, 8, number of independent channels (≥1).
- `SYNC_STAGES`, 2, synchroniser flops per channel (≥2).
- `DB_CYCLES`, 4, consecutive cycles the synchronised input must differ from the filtered level before the level is accepted (≥1).
- `DB_W`, $clog2(DB_CYCLES)+1 (derived), debounce counter width.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `signal_IN` in N_CH: raw asynchronous inputs.
- `mode` in 2*N_CH: per-channel edge select. Channel i uses bits [2i+1:2i]: 00 = off, 01 = rise, 10 = fall, 11 = both.
- `irq_en` in N_CH: per-channel interrupt enable.
- `clr` in N_CH: write-1-to-clear for `event_flag`.
- `level_out` out N_CH: debounced, filtered level.
- `pulse_out` out N_CH: one-cycle pulse on each qualifying edge.
- `event_flag` out N_CH: sticky copy of `pulse_out`.
- `irq` out 1: OR-reduction of `event_flag & irq_en`.

## Operation
- Per channel: synchroniser shift register, then a debounce counter `cnt`, then the filtered level register `lvl`.
- If the synchroniser output equals `lvl`: `cnt` ← 0.
- If the synchroniser output differs from `lvl`:
  - when `cnt == DB_CYCLES-1`: `lvl` ← synchroniser output and `cnt` ← 0;
  - otherwise `cnt` ← `cnt`+1.
- A glitch shorter than `DB_CYCLES` cycles at the synchroniser output never reaches `lvl`.
- `pulse_out[i]` is registered and high for exactly the cycle in which `lvl` changes, if the edge qualifies under `mode[i]`:
  - rise: 0→1;
  - fall: 1→0;
  - both: either direction;
  - off: never.
- The mode is sampled at the update cycle. Changing `mode` never generates a pulse by itself.
- `event_flag[i]`: set by `pulse_out[i]`, cleared by `clr[i]`. If a set and a clear occur in the same cycle, the set wins (no lost events).
- `irq` is registered from the next-state `event_flag & irq_en`, so it changes in the same cycle as `event_flag`.
- Channels are fully independent. Simultaneous edges on any subset of channels all produce pulses in the same cycle.

## Timing
- Reset values: all synchroniser flops, `cnt`, `level_out`, `pulse_out`, `event_flag` and `irq` are 0.
- `rst` asserted mid-debounce discards the partial count. No pulse is emitted during reset or in the cycle it deasserts.
- An input that is high at reset release is treated as a rising edge after the full latency, because `lvl` resets to 0.
- Latency: if `signal_IN` changes and is first captured at edge 1, then `level_out` and `pulse_out` update at edge `SYNC_STAGES+DB_CYCLES`. With defaults, that is edge 6.
- `event_flag` and `irq` assert at the same edge as `pulse_out`.
- `clr` takes effect at the next edge. `event_flag` is 0 from that edge, unless a new pulse coincides with the clear.
- Minimum accepted pulse width at the input: `DB_CYCLES` cycles. Maximum edge rate per channel: one accepted edge per `DB_CYCLES` cycles.

## Structure
- Shared package `edge_pkg`: mode encoding constants `EDGE_OFF`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`.
- Sub-module `edge_detect_ch`: one channel, containing the synchroniser, debounce counter, level register, pulse and flag. The top level instantiates `N_CH` copies in a generate loop and builds the `irq` reduction.
- No other hierarchy.

## Test plan
- Reset with channel 0 held at 0, mode=01, then drive 0→1 and hold: `level_out[0]` and `pulse_out[0]` go high at edge 6. The pulse lasts exactly 1 cycle. `event_flag[0]`=1, and with `irq_en[0]`=1, `irq`=1.
- Glitch of 3 cycles on channel 1 (`DB_CYCLES`=4): no change on `level_out[1]`, no pulse. Repeat with a 4-cycle high: accepted at edge 6.
- Mode sweep on channel 2 with a 0→1→0 input: rise gives 1 pulse, fall gives 1 pulse, both gives 2 pulses, off gives 0 pulses with `level_out` still tracking. Toggling `mode` alone gives no pulse.
- Pulse on channel 3 and `clr[3]`=1 in the same cycle: `event_flag[3]` stays 1. `clr[3]`=1 the next cycle: the flag is 0 at the following edge and `irq` drops.
- Simultaneous rising edges on all `N_CH` inputs: `pulse_out`=8'hFF for one cycle, and `event_flag`=8'hFF.
- Assert `rst` with `cnt`=2 mid-debounce and the input held high: all outputs are 0. After release, the rising edge is detected 6 cycles later with no spurious earlier pulse.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge detector bank: edge-select encoding and
// the helper that decides whether a level change qualifies for a pulse.
package edge_pkg;

    // Per-channel edge select, two bits per channel on the mode bus.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // True when a level change towards new_lvl is selected by mode.
    function automatic logic edge_qualifies(input logic [1:0] mode, input logic new_lvl);
        logic hit;
        case (edge_mode_e'(mode))
            EDGE_RISE: hit = new_lvl;
            EDGE_FALL: hit = ~new_lvl;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// One edge detector channel: synchroniser, debounce counter, filtered level,
// registered edge pulse and sticky, write-1-to-clear event flag.
module edge_detect_ch
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int DB_W        = $clog2(DB_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level_out,
    output logic       pulse_out,
    output logic       event_flag,
    output logic       flag_next
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   pulse_q, pulse_d;
    logic                   flag_q;
    logic                   sync_out;
    logic                   update;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive disagreeing cycles, accept the new level on
    // the last one; the pulse is decided in that same cycle so it lines up
    // with the level change. A set from a new pulse beats a same-cycle clear.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        update = 1'b0;
        cnt_d  = '0;
        if (sync_out != lvl_q) begin
            if (cnt_q == DB_LAST) begin
                update = 1'b1;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
        lvl_d     = update ? sync_out : lvl_q;
        pulse_d   = update & edge_qualifies(mode, sync_out);
        flag_next = pulse_d | (flag_q & ~clr);
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_next;
        end
    end

    assign level_out  = lvl_q;
    assign pulse_out  = pulse_q;
    assign event_flag = flag_q;

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of N_CH independent edge detector channels with a shared interrupt
// line raised by any enabled, pending event flag.
module edge_detect_bank
    import edge_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int DB_W        = $clog2(DB_CYCLES) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   signal_IN,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   irq_en,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   level_out,
    output logic [N_CH-1:0]   pulse_out,
    output logic [N_CH-1:0]   event_flag,
    output logic              irq
);

    logic [N_CH-1:0] flag_next;
    logic            irq_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_detect_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .DB_W        (DB_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sig_in     (signal_IN[i]),
            .mode       (mode[2*i +: 2]),
            .clr        (clr[i]),
            .level_out  (level_out[i]),
            .pulse_out  (pulse_out[i]),
            .event_flag (event_flag[i]),
            .flag_next  (flag_next[i])
        );
    end

    // Built from next-state flags so irq moves on the same edge as event_flag.
    assign irq_d = |(flag_next & irq_en);

    // Interrupt output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_d;
        end
    end

endmodule

// File: tb/tb_edge_detect_bank.sv
// Directed self-checking bench for edge_detect_bank with default parameters.
module tb_edge_detect_bank;

    localparam int N_CH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   sig_in;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   irq_en;
    logic [N_CH-1:0]   clr;
    logic [N_CH-1:0]   level_out;
    logic [N_CH-1:0]   pulse_out;
    logic [N_CH-1:0]   event_flag;
    logic              irq;

    int n_checks = 0;
    int n_pass   = 0;

    edge_detect_bank #(.N_CH(N_CH)) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_IN  (sig_in),
        .mode       (mode),
        .irq_en     (irq_en),
        .clr        (clr),
        .level_out  (level_out),
        .pulse_out  (pulse_out),
        .event_flag (event_flag),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Advance past one rising edge; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    // Run n cycles, counting pulses on a channel and noting whether its level went high.
    task automatic observe(input int ch, input int n, output int pulses, output int lvl_hi);
        pulses = 0;
        lvl_hi = 0;
        repeat (n) begin
            tick();
            if (pulse_out[ch]) pulses++;
            if (level_out[ch]) lvl_hi = 1;
        end
    endtask

    task automatic clear_flags();
        clr = '1;
        tick();
        clr = '0;
    endtask

    int p, h;
    logic [1:0] sweep_mode [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    int         sweep_exp  [4] = '{1, 1, 2, 0};

    initial begin
        rst    = 1'b1;
        sig_in = '0;
        mode   = 16'h5555;
        irq_en = 8'h01;
        clr    = '0;
        ticks(3);
        check("rst_level", 32'(level_out), 32'h0);
        check("rst_pulse", 32'(pulse_out), 32'h0);
        check("rst_flag", 32'(event_flag), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        rst = 1'b0;
        observe(0, 3, p, h);
        check("post_rst_quiet", 32'(p), 32'd0);

        // Test 1: rising edge on channel 0 lands on edge 6 for exactly one cycle.
        sig_in[0] = 1'b1;
        ticks(5);
        check("t1_lvl_e5", 32'(level_out[0]), 32'd0);
        check("t1_pulse_e5", 32'(pulse_out[0]), 32'd0);
        tick();
        check("t1_lvl_e6", 32'(level_out[0]), 32'd1);
        check("t1_pulse_e6", 32'(pulse_out[0]), 32'd1);
        check("t1_flag_e6", 32'(event_flag[0]), 32'd1);
        check("t1_irq_e6", 32'(irq), 32'd1);
        tick();
        check("t1_pulse_e7", 32'(pulse_out[0]), 32'd0);
        check("t1_flag_e7", 32'(event_flag[0]), 32'd1);

        // Test 2: a 3-cycle glitch on channel 1 is rejected; a 4-cycle high is accepted.
        sig_in[1] = 1'b1;
        ticks(3);
        sig_in[1] = 1'b0;
        observe(1, 12, p, h);
        check("t2_glitch_pulses", 32'(p), 32'd0);
        check("t2_glitch_level", 32'(h), 32'd0);
        sig_in[1] = 1'b1;
        ticks(4);
        sig_in[1] = 1'b0;
        tick();
        check("t2_accept_e5", 32'(level_out[1]), 32'd0);
        tick();
        check("t2_accept_lvl", 32'(level_out[1]), 32'd1);
        check("t2_accept_pulse", 32'(pulse_out[1]), 32'd1);
        ticks(10);
        check("t2_fall_settled", 32'(level_out[1]), 32'd0);

        // Test 3: mode sweep on channel 2 with a 0->1->0 input.
        for (int m = 0; m < 4; m++) begin
            int total, seen;
            set_mode(2, sweep_mode[m]);
            sig_in[2] = 1'b1;
            observe(2, 10, p, h);
            total = p;
            seen  = h;
            sig_in[2] = 1'b0;
            observe(2, 10, p, h);
            total += p;
            check($sformatf("t3_pulses_m%0d", sweep_mode[m]), 32'(total), 32'(sweep_exp[m]));
            check($sformatf("t3_tracked_m%0d", sweep_mode[m]), 32'(seen), 32'd1);
            check($sformatf("t3_back_low_m%0d", sweep_mode[m]), 32'(level_out[2]), 32'd0);
        end
        // Toggling mode alone while the level sits high must not pulse.
        set_mode(2, 2'b00);
        sig_in[2] = 1'b1;
        ticks(10);
        p = 0;
        for (int k = 0; k < 8; k++) begin
            set_mode(2, 2'(k));
            tick();
            if (pulse_out[2]) p++;
        end
        check("t3_mode_toggle", 32'(p), 32'd0);
        set_mode(2, 2'b00);
        sig_in[2] = 1'b0;
        ticks(10);
        set_mode(2, 2'b01);

        // Test 4: clear coinciding with a pulse loses nothing; a later clear drops flag and irq.
        irq_en = 8'h08;
        clear_flags();
        check("t4_cleared_flags", 32'(event_flag), 32'h0);
        check("t4_cleared_irq", 32'(irq), 32'd0);
        sig_in[3] = 1'b1;
        ticks(5);
        clr = 8'h08;
        tick();
        check("t4_pulse", 32'(pulse_out[3]), 32'd1);
        check("t4_set_wins", 32'(event_flag[3]), 32'd1);
        check("t4_irq_set", 32'(irq), 32'd1);
        tick();
        check("t4_flag_clr", 32'(event_flag[3]), 32'd0);
        check("t4_irq_clr", 32'(irq), 32'd0);
        clr = '0;

        // Test 5: simultaneous rising edges on every channel.
        sig_in = '0;
        ticks(12);
        clear_flags();
        sig_in = '1;
        ticks(5);
        check("t5_pulse_e5", 32'(pulse_out), 32'h00);
        tick();
        check("t5_pulse_e6", 32'(pulse_out), 32'hFF);
        check("t5_flag_e6", 32'(event_flag), 32'hFF);
        tick();
        check("t5_pulse_e7", 32'(pulse_out), 32'h00);
        check("t5_flag_e7", 32'(event_flag), 32'hFF);

        // Test 6: reset mid-debounce discards the count; detection restarts from release.
        sig_in = '0;
        ticks(12);
        clear_flags();
        irq_en = 8'hFF;
        sig_in[0] = 1'b1;
        ticks(4);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t6_rst_level", 32'(level_out), 32'h0);
            check("t6_rst_pulse", 32'(pulse_out), 32'h0);
            check("t6_rst_flag", 32'(event_flag), 32'h0);
            check("t6_rst_irq", 32'(irq), 32'd0);
        end
        rst = 1'b0;
        p = 0;
        h = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pulse_out != 0) p++;
            if (level_out != 0) h = 1;
        end
        check("t6_no_early_pulse", 32'(p), 32'd0);
        check("t6_no_early_level", 32'(h), 32'd0);
        tick();
        check("t6_pulse_e6", 32'(pulse_out), 32'h01);
        check("t6_level_e6", 32'(level_out), 32'h01);
        check("t6_irq_e6", 32'(irq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
